prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the core's 32-bit single-port instruction/data RAM (32-bit words, 1-cycle registered read, write on `we`). It consumes a byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them to consecutive RAM addresses from 0. Once the announced word count is stored, it raises `done` and hands the RAM write port to the core via a pass-through mux.

---
 rtl/prog_loader_pkg.sv | 15 +
 rtl/prog_loader.sv | 119 +++++++++++
 tb/tb_prog_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types for the boot-time program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    // Bytes in the little-endian word-count header that opens the stream.
    localparam int HDR_BYTES = 4;

endpackage

// File: rtl/prog_loader.sv
// UART byte stream -> little-endian 32-bit words written to RAM from address 0, then RAM port handed to core.
// Write pulse one cycle after the 4th byte of a word; no backpressure, accepts a byte every cycle.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MEM = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    input  logic           cpu_we,
    input  logic [MEM-1:0] cpu_addr,
    input  logic [31:0]    cpu_din,
    output logic           ram_we,
    output logic [MEM-1:0] ram_addr,
    output logic [31:0]    ram_din,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam logic [32:0] CAPACITY = 33'd1 << MEM;

    state_t         state, state_nxt;
    logic [1:0]     byte_idx;
    logic [MEM:0]   word_idx;
    logic [31:0]    len_q;
    logic [31:0]    word_q;
    logic           ld_we;
    logic [MEM-1:0] ld_addr;
    logic [31:0]    ld_din;

    logic [31:0]    len_nxt;
    logic           hdr_last;
    logic           all_written;

    assign len_nxt     = {rx_data, len_q[31:8]};
    assign hdr_last    = rx_valid && (byte_idx == 2'(HDR_BYTES - 1));
    // True in the cycle carrying the final write pulse, so FLUSH follows it.
    assign all_written = ({{(31 - MEM){1'b0}}, word_idx} == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN: begin
                if (hdr_last) begin
                    if (len_nxt == 32'd0) begin
                        state_nxt = S_DONE;
                    end else if ({1'b0, len_nxt} > CAPACITY) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (all_written) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: state_nxt = S_DONE;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= 2'd0;
            word_idx <= '0;
            len_q    <= 32'd0;
            word_q   <= 32'd0;
            ld_we    <= 1'b0;
            ld_addr  <= '0;
            ld_din   <= 32'd0;
        end else begin
            ld_we <= 1'b0;
            case (state)
                S_LEN: begin
                    if (rx_valid) begin
                        len_q    <= len_nxt;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_DATA: begin
                    if (rx_valid && !all_written) begin
                        word_q[{byte_idx, 3'b000} +: 8] <= rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (&byte_idx) begin
                            ld_we    <= 1'b1;
                            ld_addr  <= word_idx[MEM-1:0];
                            ld_din   <= {rx_data, word_q[23:0]};
                            word_idx <= word_idx + (MEM + 1)'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = (state == S_DONE);
    assign err  = (state == S_ERR);
    assign busy = !done && !err;

    // Core owns the RAM port once loading is finished; no register in this path.
    assign ram_we   = done ? cpu_we   : ld_we;
    assign ram_addr = done ? cpu_addr : ld_addr;
    assign ram_din  = done ? cpu_din  : ld_din;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (MEM=10 and MEM=4) fed the same byte stream, write scoreboard per instance.
module tb_prog_loader;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = 10'd0;
    logic [31:0] cpu_din = 32'd0;

    logic        ram_we_a, busy_a, done_a, err_a;
    logic [9:0]  ram_addr_a;
    logic [31:0] ram_din_a;
    logic        ram_we_b, busy_b, done_b, err_b;
    logic [3:0]  ram_addr_b;
    logic [31:0] ram_din_b;

    wr_t         qa[$];
    wr_t         qb[$];
    wr_t         ea, eb;
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:15];
    logic [31:0] img   [0:1023];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          space_en = 1'b0;
    int          prev_a = -1;
    int          npulse = 0;

    prog_loader #(.MEM(10)) u_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_din(ram_din_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    prog_loader #(.MEM(4)) u_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr[3:0]), .cpu_din(cpu_din),
        .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_din(ram_din_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gen(input int k, input int seed);
        return (32'(k) * 32'h9E3779B9) ^ (32'(seed) << 24) ^ 32'h5A5A_0000;
    endfunction

    // Loader writes are popped against the scoreboard; every write also lands in the RAM models.
    always @(negedge clk) begin
        if (ram_we_a) begin
            if (!done_a) begin
                if (qa.size() == 0) begin
                    chk("wr_a_unexpected", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    chk("wr_a_addr", ram_addr_a, ea.addr);
                    chk("wr_a_dat", ram_din_a, ea.dat);
                end
                if (space_en) begin
                    if (prev_a >= 0) chk("wr_a_spacing", cyc - prev_a, 4);
                    prev_a = cyc;
                    npulse++;
                end
            end
            mem_a[ram_addr_a] = ram_din_a;
        end
        if (ram_we_b) begin
            if (!done_b) begin
                if (qb.size() == 0) begin
                    chk("wr_b_unexpected", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    chk("wr_b_addr", ram_addr_b, eb.addr[3:0]);
                    chk("wr_b_dat", ram_din_b, eb.dat);
                end
            end
            mem_b[ram_addr_b] = ram_din_b;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic load_body(input int n, input int gap, input int seed);
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            w = gen(k, seed);
            img[k] = w;
            if (n <= 1024) qa.push_back('{addr: 10'(k), dat: w});
            if (n <= 16)   qb.push_back('{addr: 10'(k), dat: w});
            send_word(w, gap);
        end
    endtask

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 40 && !done_a; i++) @(negedge clk);
        chk(tag, done_a, 1);
    endtask

    // Leaves rst deasserted with the bench aligned just after a rising edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_we"},   ram_we_a, 0);
        chk({tag, "_addr"}, ram_addr_a, 0);
        chk({tag, "_din"},  ram_din_a, 0);
        chk({tag, "_busy"}, busy_a, 1);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_err"},  err_a, 0);
        chk({tag, "_err_b"}, err_b, 0);
        chk({tag, "_qa_empty"}, qa.size(), 0);
        chk({tag, "_qb_empty"}, qb.size(), 0);
        qa.delete();
        qb.delete();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] s2 [0:11];
        s2 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 1024; i++) mem_a[i] = 32'd0;
        for (int i = 0; i < 16; i++)   mem_b[i] = 32'd0;

        // Core tries to write throughout the first load; it must not leak through.
        cpu_we   = 1'b1;
        cpu_addr = 10'd5;
        cpu_din  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        do_reset("rst0");
        @(negedge clk);
        chk("cpu_blocked_we", ram_we_a, 0);
        chk("cpu_blocked_addr", ram_addr_a, 0);
        @(posedge clk);
        #1;

        // N=2 reference image, one idle cycle between bytes
        qa.push_back('{addr: 10'd0, dat: 32'h1234_5678});
        qa.push_back('{addr: 10'd1, dat: 32'hDEAD_BEEF});
        qb.push_back('{addr: 10'd0, dat: 32'h1234_5678});
        qb.push_back('{addr: 10'd1, dat: 32'hDEAD_BEEF});
        for (int i = 0; i < 12; i++) send_byte(s2[i], 1);
        @(negedge clk);
        chk("n2_last_pulse", ram_we_a, 1);
        chk("n2_last_done", done_a, 0);
        @(negedge clk);
        chk("n2_flush_done", done_a, 0);
        chk("n2_flush_busy", busy_a, 1);
        @(negedge clk);
        chk("n2_done", done_a, 1);
        chk("n2_busy", busy_a, 0);
        chk("n2_rb0", mem_a[0], 32'h1234_5678);
        chk("n2_rb1", mem_a[1], 32'hDEAD_BEEF);
        chk("cpu_pass_we", ram_we_a, 1);
        chk("cpu_pass_addr", ram_addr_a, 5);
        chk("cpu_pass_din", ram_din_a, 32'hCAFE_F00D);
        cpu_addr = 10'd7;
        #1;
        chk("cpu_pass_addr_comb", ram_addr_a, 7);
        cpu_we = 1'b0;
        #1;
        chk("cpu_pass_we_comb", ram_we_a, 0);
        send_byte(8'h55, 0);
        @(negedge clk);
        chk("done_ignores_rx", done_a, 1);
        @(posedge clk);
        #1;

        // N=0: done straight after the header
        do_reset("rst_n0");
        send_word(32'd0, 0);
        @(negedge clk);
        chk("n0_done_a", done_a, 1);
        chk("n0_done_b", done_b, 1);
        chk("n0_we", ram_we_a, 0);
        @(posedge clk);
        #1;

        // N=17: overflows MEM=4 instance, legal for MEM=10, full rate
        do_reset("rst_n17");
        send_word(32'd17, 0);
        @(negedge clk);
        chk("n17_err_b", err_b, 1);
        chk("n17_done_b", done_b, 0);
        chk("n17_busy_b", busy_b, 0);
        chk("n17_err_a", err_a, 0);
        chk("n17_busy_a", busy_a, 1);
        @(posedge clk);
        #1;
        load_body(17, 0, 1);
        wait_done_a("n17_done_a");
        chk("n17_err_b_sticky", err_b, 1);
        chk("n17_done_b_end", done_b, 0);
        for (int k = 0; k < 17; k++) chk("n17_rb_a", mem_a[k], img[k]);
        @(posedge clk);
        #1;

        // N=16: fills MEM=4 RAM exactly, full rate, pulses 4 cycles apart
        do_reset("rst_n16");
        space_en = 1'b1;
        prev_a   = -1;
        npulse   = 0;
        send_word(32'd16, 0);
        load_body(16, 0, 2);
        wait_done_a("n16_done_a");
        chk("n16_done_b", done_b, 1);
        chk("n16_err_b", err_b, 0);
        chk("n16_pulses", npulse, 16);
        for (int k = 0; k < 16; k++) chk("n16_rb_b", mem_b[k], img[k]);
        @(posedge clk);
        #1;

        // N=3 full rate
        do_reset("rst_n3");
        prev_a = -1;
        npulse = 0;
        send_word(32'd3, 0);
        load_body(3, 0, 3);
        wait_done_a("n3_done_a");
        chk("n3_pulses", npulse, 3);
        for (int k = 0; k < 3; k++) chk("n3_rb_a", mem_a[k], img[k]);
        space_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset after 6 bytes, then a fresh single-word load
        do_reset("rst_pre_mid");
        send_word(32'd2, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_reset("rst_mid");
        qa.push_back('{addr: 10'd0, dat: 32'hDDCC_BBAA});
        qb.push_back('{addr: 10'd0, dat: 32'hDDCC_BBAA});
        send_word(32'd1, 0);
        send_word(32'hDDCC_BBAA, 0);
        wait_done_a("fresh_done_a");
        chk("fresh_rb_a", mem_a[0], 32'hDDCC_BBAA);
        chk("fresh_rb_b", mem_b[0], 32'hDDCC_BBAA);

        chk("end_qa_empty", qa.size(), 0);
        chk("end_qb_empty", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
